// File: rtl/usb_ctrl_xfer_host.sv
// usb_ctrl_xfer_host
//   Host-side control transfer sequencer for endpoint 0. Drives the SETUP,
//   optional DATA and STATUS stages through the host packet engine, tracks
//   DATA0/DATA1 toggles, splits the data stage into MAX_PKT transactions and
//   replays NAKed transactions from their first byte.
//
// Configuration macro: USB_CTRL_NAK_RETRY_EN
//   defined   - NAKs are retried until more than NAK_LIMIT in a row, then status 2
//   undefined - the first NAK ends the transfer with status 2
//
// Ports
//   clk, reset           clock, synchronous active-low reset
//   dev_addr, req_*      request side: address and setup fields, start pulse,
//                        busy / done / status back
//   tok_*, tx_len        transaction launch towards the packet engine
//   tx_get, tx_data      payload pull for SETUP/OUT
//   rx_valid, rx_data    IN payload from the engine
//   xact_*               transaction completion report
//   app_rd_*             IN data-stage bytes to the application
//   app_wr_get/_data     OUT data-stage bytes from the application
//
// state  | meaning
// IDLE   | waiting for req_start
// SETUP  | 8-byte SETUP transaction
// DATA   | data stage, one transaction per MAX_PKT chunk (dir_in selects IN/OUT)
// STATUS | zero-length handshake, opposite direction to the data stage
// DONE   | one-cycle req_done pulse

module usb_ctrl_xfer_host #(
    parameter int MAX_PKT   = 32,
    parameter int NAK_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  dev_addr,
    input  logic        req_start,
    input  logic [7:0]  req_bmRequestType,
    input  logic [7:0]  req_bRequest,
    input  logic [15:0] req_wValue,
    input  logic [15:0] req_wIndex,
    input  logic [15:0] req_wLength,
    output logic        req_busy,
    output logic        req_done,
    output logic [1:0]  req_status,
    output logic        tok_start,
    output logic [1:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic        tok_data1,
    output logic [6:0]  tx_len,
    input  logic        tx_get,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        xact_done,
    input  logic [1:0]  xact_result,
    input  logic [6:0]  xact_rx_len,
    output logic        app_rd_valid,
    output logic [7:0]  app_rd_data,
    output logic        app_wr_get,
    input  logic [7:0]  app_wr_data
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_DATA, ST_STATUS, ST_DONE} state_t;

    localparam logic [6:0]  PKT7      = 7'(MAX_PKT);
    localparam logic [15:0] PKT16     = 16'(MAX_PKT);
    localparam logic [1:0]  PID_SETUP = 2'd0;
    localparam logic [1:0]  PID_OUT   = 2'd1;
    localparam logic [1:0]  PID_IN    = 2'd2;
    localparam logic [1:0]  RES_ACK   = 2'd0;
    localparam logic [1:0]  RES_NAK   = 2'd1;
    localparam logic [1:0]  RES_STALL = 2'd2;

    state_t      state_q, state_d;
    logic        launched_q, launched_d;   // token issued, waiting for xact_done
    logic        dir_in_q, dir_in_d;
    logic        toggle_q, toggle_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] remaining_q, remaining_d;
    logic [63:0] setup_q, setup_d;
    logic [6:0]  addr_q, addr_d;
    logic [1:0]  status_q, status_d;

    logic [6:0]  out_len;
    logic [15:0] in_take;
    logic [15:0] rem_after;
    logic        nak_over;
    logic        nak_hit;

    assign tok_addr = addr_q;
    assign out_len  = (remaining_q < PKT16) ? remaining_q[6:0] : PKT7;
    // IN bytes beyond wLength are not counted, so remaining saturates at 0.
    assign in_take  = ({9'd0, xact_rx_len} < remaining_q) ? {9'd0, xact_rx_len} : remaining_q;
    assign rem_after = remaining_q - (dir_in_q ? in_take : {9'd0, out_len});
    assign nak_hit  = launched_q && xact_done && (xact_result == RES_NAK) &&
                      (state_q == ST_SETUP || state_q == ST_DATA || state_q == ST_STATUS);

`ifdef USB_CTRL_NAK_RETRY_EN
    logic [8:0] nak_cnt_q;
    logic       retry_q;    // next tok_start is a replay, keep the NAK count

    assign nak_over = (int'(nak_cnt_q) + 1) > NAK_LIMIT;

    always_ff @(posedge clk) begin
        if (!reset || state_q == ST_IDLE) begin
            nak_cnt_q <= 9'd0;
            retry_q   <= 1'b0;
        end else if (nak_hit) begin
            nak_cnt_q <= nak_cnt_q + 9'd1;
            retry_q   <= 1'b1;
        end else if (tok_start) begin
            if (!retry_q) nak_cnt_q <= 9'd0;
            retry_q <= 1'b0;
        end
    end
`else
    logic nak_limit_unused;
    assign nak_limit_unused = (NAK_LIMIT > 0) & nak_hit;
    assign nak_over = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            launched_q  <= 1'b0;
            dir_in_q    <= 1'b0;
            toggle_q    <= 1'b0;
            byte_cnt_q  <= 7'd0;
            remaining_q <= 16'd0;
            setup_q     <= 64'd0;
            addr_q      <= 7'd0;
            status_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            launched_q  <= launched_d;
            dir_in_q    <= dir_in_d;
            toggle_q    <= toggle_d;
            byte_cnt_q  <= byte_cnt_d;
            remaining_q <= remaining_d;
            setup_q     <= setup_d;
            addr_q      <= addr_d;
            status_q    <= status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        launched_d   = launched_q;
        dir_in_d     = dir_in_q;
        toggle_d     = toggle_q;
        byte_cnt_d   = byte_cnt_q;
        remaining_d  = remaining_q;
        setup_d      = setup_q;
        addr_d       = addr_q;
        status_d     = status_q;
        req_busy     = 1'b0;
        req_done     = 1'b0;
        req_status   = 2'd0;
        tok_start    = 1'b0;
        tok_pid      = PID_SETUP;
        tok_data1    = 1'b0;
        tx_len       = 7'd0;
        tx_data      = 8'd0;
        app_rd_valid = 1'b0;
        app_rd_data  = 8'd0;
        app_wr_get   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_busy = req_start;
                if (req_start) begin
                    addr_d      = dev_addr;
                    setup_d     = {req_wLength, req_wIndex, req_wValue,
                                   req_bRequest, req_bmRequestType};
                    remaining_d = req_wLength;
                    byte_cnt_d  = 7'd0;
                    toggle_d    = 1'b0;
                    dir_in_d    = 1'b0;
                    launched_d  = 1'b0;
                    status_d    = 2'd0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP, ST_DATA, ST_STATUS: begin
                req_busy = 1'b1;
                if (state_q == ST_SETUP) begin
                    tx_len = 7'd8;
                    if (byte_cnt_q < 7'd8)
                        tx_data = setup_q[{byte_cnt_q[2:0], 3'b000} +: 8];
                end else begin
                    tok_pid   = dir_in_q ? PID_IN : PID_OUT;
                    tok_data1 = (state_q == ST_STATUS) ? 1'b1 : toggle_q;
                    if (state_q == ST_DATA && !dir_in_q) begin
                        tx_len     = out_len;
                        tx_data    = app_wr_data;
                        app_wr_get = tx_get;
                    end
                end

                if (!launched_q) begin
                    // Fresh launch or NAK replay: payload restarts at byte 0.
                    tok_start  = 1'b1;
                    launched_d = 1'b1;
                    byte_cnt_d = 7'd0;
                end else begin
                    if (tx_get && (state_q == ST_SETUP || (state_q == ST_DATA && !dir_in_q)))
                        byte_cnt_d = byte_cnt_q + 7'd1;
                    if (rx_valid && state_q == ST_DATA && dir_in_q) begin
                        byte_cnt_d = byte_cnt_q + 7'd1;
                        if ({9'd0, byte_cnt_q} < remaining_q) begin
                            app_rd_valid = 1'b1;
                            app_rd_data  = rx_data;
                        end
                    end

                    if (xact_done) begin
                        launched_d = 1'b0;
                        case (xact_result)
                            RES_ACK: begin
                                if (state_q == ST_SETUP) begin
                                    toggle_d = 1'b1;
                                    if (setup_q[63:48] == 16'd0) begin
                                        state_d  = ST_STATUS;
                                        dir_in_d = 1'b1;
                                    end else begin
                                        state_d  = ST_DATA;
                                        dir_in_d = setup_q[7];
                                    end
                                end else if (state_q == ST_DATA) begin
                                    toggle_d    = ~toggle_q;
                                    remaining_d = rem_after;
                                    if (dir_in_q) begin
                                        if (xact_rx_len < PKT7 || rem_after == 16'd0) begin
                                            state_d  = ST_STATUS;
                                            dir_in_d = 1'b0;
                                        end
                                    end else if (rem_after == 16'd0) begin
                                        state_d  = ST_STATUS;
                                        dir_in_d = 1'b1;
                                    end
                                end else begin
                                    state_d  = ST_DONE;
                                    status_d = (dir_in_q && xact_rx_len != 7'd0) ? 2'd3 : 2'd0;
                                end
                            end
                            RES_NAK: begin
                                if (nak_over) begin
                                    state_d  = ST_DONE;
                                    status_d = 2'd2;
                                end
                            end
                            RES_STALL: begin
                                state_d  = ST_DONE;
                                status_d = 2'd1;
                            end
                            default: begin
                                state_d  = ST_DONE;
                                status_d = 2'd3;
                            end
                        endcase
                    end
                end
            end

            ST_DONE: begin
                req_done   = 1'b1;
                req_status = status_q;
                state_d    = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_ctrl_xfer_host.sv
`timescale 1ns/1ps
module tb_usb_ctrl_xfer_host;
    localparam int MAXP = 32;
    localparam int NLIM = 3;
`ifdef USB_CTRL_NAK_RETRY_EN
    localparam int MODEL_LIM = NLIM;
`else
    localparam int MODEL_LIM = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic        req_start = 1'b0;
    logic [7:0]  req_bmRequestType = '0, req_bRequest = '0;
    logic [15:0] req_wValue = '0, req_wIndex = '0, req_wLength = '0;
    logic        req_busy, req_done;
    logic [1:0]  req_status;
    logic        tok_start;
    logic [1:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic        tok_data1;
    logic [6:0]  tx_len;
    logic        tx_get = 1'b0;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        xact_done = 1'b0;
    logic [1:0]  xact_result = '0;
    logic [6:0]  xact_rx_len = '0;
    logic        app_rd_valid;
    logic [7:0]  app_rd_data;
    logic        app_wr_get;
    logic [7:0]  app_wr_data;

    usb_ctrl_xfer_host #(.MAX_PKT(MAXP), .NAK_LIMIT(NLIM)) dut (
        .clk(clk), .reset(reset), .dev_addr(dev_addr), .req_start(req_start),
        .req_bmRequestType(req_bmRequestType), .req_bRequest(req_bRequest),
        .req_wValue(req_wValue), .req_wIndex(req_wIndex), .req_wLength(req_wLength),
        .req_busy(req_busy), .req_done(req_done), .req_status(req_status),
        .tok_start(tok_start), .tok_pid(tok_pid), .tok_addr(tok_addr),
        .tok_data1(tok_data1), .tx_len(tx_len), .tx_get(tx_get), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .xact_done(xact_done),
        .xact_result(xact_result), .xact_rx_len(xact_rx_len),
        .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
        .app_wr_get(app_wr_get), .app_wr_data(app_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    logic [9:0]  exp_tok[$];
    logic [7:0]  exp_rd[$];
    int          exp_status = -1;
    logic [6:0]  exp_addr = '0;
    logic [1:0]  res_q[$];
    int          rlen_q[$];
    int tok_seen, rd_seen, wr_seen, done_seen, last_status;
    int wr_base = 0, wr_idx = 0;

    function automatic logic [7:0] rxb(input int k, input int j);
        return 8'(k * 37 + j + 3);
    endfunction

    function automatic logic [7:0] wrb(input int i);
        return 8'(i * 7 + 17);
    endfunction

    always_comb app_wr_data = wrb(wr_base + wr_idx);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int r, input int l);
        res_q.push_back(2'(r));
        rlen_q.push_back(l);
    endtask

    // Transfer-level model: walks the engine's response script through the
    // stage rules and lists the tokens, forwarded IN bytes and final status.
    function automatic void model(input logic [7:0] bm, input logic [15:0] wlen);
        int stage, rem, naks, len, n;
        bit din, tog, d1;
        logic [1:0] pid;
        stage = 0; rem = int'(wlen); naks = 0; din = 0; tog = 0;
        exp_status = -1;
        for (int k = 0; k < res_q.size(); k++) begin
            if (stage == 0) begin
                pid = 2'd0; d1 = 0; len = 8;
            end else if (stage == 1) begin
                pid = din ? 2'd2 : 2'd1; d1 = tog;
                len = din ? 0 : ((rem < MAXP) ? rem : MAXP);
            end else begin
                pid = din ? 2'd2 : 2'd1; d1 = 1; len = 0;
            end
            exp_tok.push_back({pid, d1, 7'(len)});
            if (res_q[k] == 2'd1) begin
                naks++;
                if (naks > MODEL_LIM) begin exp_status = 2; return; end
            end else if (res_q[k] == 2'd2) begin
                exp_status = 1; return;
            end else if (res_q[k] == 2'd3) begin
                exp_status = 3; return;
            end else begin
                naks = 0;
                if (stage == 0) begin
                    tog = 1;
                    if (wlen == 16'd0) begin stage = 2; din = 1; end
                    else begin stage = 1; din = bm[7]; end
                end else if (stage == 1) begin
                    tog = !tog;
                    if (din) begin
                        n = (rlen_q[k] < rem) ? rlen_q[k] : rem;
                        for (int j = 0; j < n; j++) exp_rd.push_back(rxb(k, j));
                        rem = rem - n;
                        if (rlen_q[k] < MAXP || rem == 0) begin stage = 2; din = 0; end
                    end else begin
                        rem = rem - len;
                        if (rem == 0) begin stage = 2; din = 1; end
                    end
                end else begin
                    exp_status = (din && rlen_q[k] != 0) ? 3 : 0;
                    return;
                end
            end
        end
    endfunction

    // Compare process: outputs checked against the model queues every cycle.
    always begin
        logic [9:0] et;
        @(negedge clk);
        #3;
        if (reset) begin
            if (tok_start) begin
                tok_seen++;
                if (exp_tok.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL tok_extra: got pid %0d len %0d expected none", tok_pid, tx_len);
                end else begin
                    et = exp_tok.pop_front();
                    check("tok_pid_d1_len", {22'd0, tok_pid, tok_data1, tx_len}, {22'd0, et});
                    check("tok_addr", {25'd0, tok_addr}, {25'd0, exp_addr});
                end
            end
            if (app_rd_valid) begin
                rd_seen++;
                if (exp_rd.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_extra: got %0h expected none", app_rd_data);
                end else begin
                    check("app_rd_data", {24'd0, app_rd_data}, {24'd0, exp_rd.pop_front()});
                end
            end
            if (app_wr_get) wr_seen++;
            if (req_done) begin
                done_seen++;
                last_status = int'(req_status);
                check("req_status", {30'd0, req_status}, exp_status);
                check("busy_at_done", {31'd0, req_busy}, 32'd0);
            end
        end
    end

    task automatic run_xfer(input logic [6:0] addr, input logic [7:0] bm, input logic [7:0] breq,
                            input logic [15:0] wv, input logic [15:0] wi, input logic [15:0] wl,
                            input bit poke, input bit spur);
        logic [7:0] sb[8];
        logic [7:0] eb;
        logic [1:0] pid;
        int k, t0, len, n_exp;
        bit fin;
        sb[0] = bm; sb[1] = breq; sb[2] = wv[7:0]; sb[3] = wv[15:8];
        sb[4] = wi[7:0]; sb[5] = wi[15:8]; sb[6] = wl[7:0]; sb[7] = wl[15:8];
        exp_tok.delete(); exp_rd.delete(); exp_addr = addr;
        model(bm, wl);
        n_exp = exp_tok.size();
        tok_seen = 0; rd_seen = 0; wr_seen = 0; done_seen = 0; last_status = -1;
        wr_base = 0; wr_idx = 0;
        @(negedge clk);
        dev_addr = addr; req_bmRequestType = bm; req_bRequest = breq;
        req_wValue = wv; req_wIndex = wi; req_wLength = wl; req_start = 1'b1;
        #1 check("busy_on_start", {31'd0, req_busy}, 32'd1);
        @(negedge clk);
        req_start = 1'b0; dev_addr = ~addr;
        req_bmRequestType = 8'hEE; req_bRequest = 8'hEE;
        req_wValue = 16'hDEAD; req_wIndex = 16'hBEEF; req_wLength = 16'h0;
        k = 0; fin = 0; t0 = cyc;
        while (!fin) begin
            #1;
            if (cyc - t0 > 3000) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: got no req_done after %0d cycles expected done", cyc - t0);
                fin = 1;
            end else if (req_done) begin
                fin = 1;
            end else if (tok_start) begin
                pid = tok_pid; len = int'(tx_len); wr_idx = 0;
                if (k >= res_q.size()) begin
                    n_chk++; n_fail++;
                    $display("FAIL script_overrun: got token %0d expected none", k);
                    fin = 1;
                end else begin
                    if (spur && k == 0) begin
                        xact_done = 1'b1; xact_result = 2'd2; rx_valid = 1'b1; rx_data = 8'h5A;
                    end
                    if (poke && k == 1) begin req_start = 1'b1; dev_addr = 7'h55; end
                    @(negedge clk);
                    xact_done = 1'b0; rx_valid = 1'b0; req_start = 1'b0;
                    if (pid == 2'd2) begin
                        for (int j = 0; j < rlen_q[k]; j++) begin
                            rx_valid = 1'b1; rx_data = rxb(k, j);
                            @(negedge clk);
                        end
                        rx_valid = 1'b0;
                    end else begin
                        for (int i = 0; i < len; i++) begin
                            wr_idx = i; tx_get = 1'b1;
                            #1;
                            if (pid == 2'd0) eb = sb[i & 7];
                            else eb = wrb(wr_base + i);
                            check("tx_data", {24'd0, tx_data}, {24'd0, eb});
                            @(negedge clk);
                        end
                        tx_get = 1'b0;
                    end
                    xact_done = 1'b1; xact_result = res_q[k]; xact_rx_len = 7'(rlen_q[k]);
                    if (pid == 2'd1 && res_q[k] == 2'd0) wr_base = wr_base + len;
                    @(negedge clk);
                    xact_done = 1'b0;
                    k++;
                    if (k == n_exp) begin
                        #1 check("done_latency", {31'd0, req_done}, 32'd1);
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        #4;
        check("tok_left", exp_tok.size(), 32'd0);
        check("rd_left", exp_rd.size(), 32'd0);
        check("done_count", done_seen, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", {req_busy, req_done, tok_start, tok_pid, tok_data1, tx_len,
                                   tok_addr, app_rd_valid, app_wr_get, req_status, tx_data}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // GET_DESCRIPTOR device, 18 bytes in one IN; busy re-start ignored
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 18); add(0, 0);
        run_xfer(7'h12, 8'h80, 8'h06, 16'h0100, 16'h0000, 16'd18, 1, 0);
        check("t1_tokens", tok_seen, 32'd3);
        check("t1_rd", rd_seen, 32'd18);
        check("t1_status", last_status, 32'd0);

        // GET_DESCRIPTOR config, 67 bytes as 32/32/3
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 32); add(0, 32); add(0, 3); add(0, 0);
        run_xfer(7'h12, 8'h80, 8'h06, 16'h0200, 16'h0000, 16'd67, 0, 0);
        check("t2_tokens", tok_seen, 32'd5);
        check("t2_rd", rd_seen, 32'd67);

        // SET_ADDRESS 5, spurious xact_done / rx_valid in the launch cycle
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 0);
        run_xfer(7'h00, 8'h00, 8'h05, 16'h0005, 16'h0000, 16'd0, 0, 1);
        check("t3_tokens", tok_seen, 32'd2);
        check("t3_rd", rd_seen, 32'd0);
        check("t3_status", last_status, 32'd0);

        // SET_LINE_CODING, 7-byte OUT NAKed once
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(1, 0); add(0, 0); add(0, 0);
        run_xfer(7'h21, 8'h21, 8'h20, 16'h0000, 16'h0000, 16'd7, 0, 0);
`ifdef USB_CTRL_NAK_RETRY_EN
        check("t4_tokens", tok_seen, 32'd4);
        check("t4_wr", wr_seen, 32'd14);
        check("t4_status", last_status, 32'd0);
`else
        check("t4_tokens", tok_seen, 32'd2);
        check("t4_wr", wr_seen, 32'd7);
        check("t4_status", last_status, 32'd2);
`endif

        // STALL in DATA IN
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(2, 0);
        run_xfer(7'h03, 8'h80, 8'h06, 16'h0300, 16'h0409, 16'd64, 0, 0);
        check("t5_tokens", tok_seen, 32'd2);
        check("t5_status", last_status, 32'd1);

        // NAK limit on DATA IN
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(1, 0); add(1, 0); add(1, 0); add(1, 0); add(0, 8); add(0, 0);
        run_xfer(7'h04, 8'h80, 8'h00, 16'h0000, 16'h0000, 16'd8, 0, 0);
`ifdef USB_CTRL_NAK_RETRY_EN
        check("t6_tokens", tok_seen, 32'd5);
`else
        check("t6_tokens", tok_seen, 32'd2);
`endif
        check("t6_status", last_status, 32'd2);

        // device over-delivers: 12 bytes for wLength=10
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 12); add(0, 0);
        run_xfer(7'h05, 8'hC0, 8'h01, 16'h0000, 16'h0000, 16'd10, 0, 0);
        check("t7_rd", rd_seen, 32'd10);
        check("t7_tokens", tok_seen, 32'd3);

        // IN status returning data -> bus error
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 2);
        run_xfer(7'h06, 8'h00, 8'h09, 16'h0001, 16'h0000, 16'd0, 0, 0);
        check("t8_status", last_status, 32'd3);
        check("t8_rd", rd_seen, 32'd0);

        // error on SETUP
        res_q.delete(); rlen_q.delete();
        add(3, 0);
        run_xfer(7'h07, 8'h00, 8'h09, 16'h0001, 16'h0000, 16'd0, 0, 0);
        check("t9_status", last_status, 32'd3);
        check("t9_tokens", tok_seen, 32'd1);

        // IN of exactly 2*MAX_PKT: ends on remaining=0, no short packet
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 32); add(0, 32); add(0, 0);
        run_xfer(7'h08, 8'h80, 8'h06, 16'h0300, 16'h0000, 16'd64, 0, 0);
        check("t10_tokens", tok_seen, 32'd4);
        check("t10_rd", rd_seen, 32'd64);

        // OUT of 40 bytes as 32 + 8
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 0); add(0, 0); add(0, 0);
        run_xfer(7'h09, 8'h40, 8'h10, 16'h1234, 16'h5678, 16'd40, 0, 0);
        check("t11_tokens", tok_seen, 32'd4);
        check("t11_wr", wr_seen, 32'd40);

        // reset mid-transfer: silent abort
        exp_tok.delete(); exp_rd.delete(); exp_addr = 7'h11;
        exp_tok.push_back({2'd0, 1'b0, 7'd8});
        tok_seen = 0; done_seen = 0;
        @(negedge clk);
        dev_addr = 7'h11; req_bmRequestType = 8'h80; req_wLength = 16'd8; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        repeat (3) @(negedge clk);
        tx_get = 1'b1;
        @(negedge clk);
        tx_get = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("busy_after_reset", {31'd0, req_busy}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #4;
        check("abort_no_done", done_seen, 32'd0);
        check("abort_tokens", tok_seen, 32'd1);

        // clean transfer after the abort
        res_q.delete(); rlen_q.delete();
        add(0, 0); add(0, 0);
        run_xfer(7'h0A, 8'h00, 8'h05, 16'h000A, 16'h0000, 16'd0, 0, 0);
        check("t12_status", last_status, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_ctrl_xfer_host.md
# usb_ctrl_xfer_host

Host-side USB control transfer sequencer for endpoint 0: the initiator that drives SETUP, DATA and STATUS stages against a device control endpoint. It sits between a request source (test harness or host firmware bridge) and the host packet engine, which serialises tokens and data packets and reports handshakes. It tracks data toggles, splits the data stage into max-packet transactions, and retries NAKed transactions.

## Interface
- MAX_PKT, 32: endpoint 0 max packet size in bytes, valid range 8..64.
- NAK_LIMIT, 255: consecutive NAKs tolerated per transaction. Only used with USB_CTRL_NAK_RETRY_EN.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- dev_addr  in  7  target device address, sampled at req_start.
- req_start  in  1  one-cycle pulse that starts a transfer. Ignored unless req_busy=0.
- req_bmRequestType, req_bRequest  in  8 each  setup fields.
- req_wValue, req_wIndex, req_wLength  in  16 each  setup fields.
- req_busy  out  1  high from the req_start cycle until req_done.
- req_done  out  1  one-cycle completion pulse.
- req_status  out  2  valid on req_done: 0=OK, 1=STALL, 2=NAK limit, 3=bus error.
- tok_start  out  1  one-cycle pulse that launches one transaction.
- tok_pid  out  2  0=SETUP, 1=OUT, 2=IN. Held stable while a transaction is outstanding.
- tok_addr  out  7  latched dev_addr.
- tok_data1  out  1  data PID for SETUP/OUT (0=DATA0); expected PID for IN.
- tx_len  out  7  payload length for SETUP/OUT.
- tx_get  in  1  engine consumes tx_data this cycle.
- tx_data  out  8  current payload byte, combinational from the byte counter.
- rx_valid  in  1  IN payload byte strobe from the engine.
- rx_data  in  8  IN payload byte.
- xact_done  in  1  transaction finished.
- xact_result  in  2  0=ACK, 1=NAK, 2=STALL, 3=error.
- xact_rx_len  in  7  IN bytes received in this transaction.
- app_rd_valid  out  1  IN data-stage byte forwarded to the application.
- app_rd_data  out  8  byte forwarded with app_rd_valid.
- app_wr_get  out  1  pulse requesting the next OUT data-stage byte.
- app_wr_data  in  8  OUT data-stage byte.

## Operation
- States: IDLE, SETUP, DATA, STATUS, DONE. Each active state launches a transaction, then waits for xact_done.
- **IDLE**
  - On req_start, latch dev_addr and all request fields.
  - Clear byte_cnt, clear remaining=wLength, set toggle=0.
  - Go to SETUP.
- **SETUP**
  - tok_pid=SETUP, tok_data1=0, tx_len=8.
  - Each tx_get advances the byte index. Bytes are returned in order: bmRequestType, bRequest, wValue lo, wValue hi, wIndex lo, wIndex hi, wLength lo, wLength hi.
  - On ACK, set toggle=1. Then:
    - wLength=0 → STATUS as IN.
    - otherwise → DATA, direction IN if bmRequestType[7]=1, else OUT.
- **DATA IN**
  - tok_pid=IN. rx bytes pass straight to app_rd_valid/app_rd_data in the same cycle.
  - On ACK: toggle inverts; remaining -= min(xact_rx_len, remaining).
  - Stage ends when xact_rx_len < MAX_PKT or remaining=0. Status direction is then OUT.
  - Bytes past wLength are dropped and never forwarded.
- **DATA OUT**
  - tok_pid=OUT, tx_len=min(MAX_PKT, remaining).
  - tx_get drives app_wr_get in the same cycle; tx_data=app_wr_data.
  - On ACK: toggle inverts; remaining -= tx_len.
  - Stage ends when remaining=0. Status direction is then IN.
- **STATUS**
  - Zero-length transaction, always tok_data1=1, direction opposite to the data stage.
  - ACK with zero length → DONE, status OK.
  - An IN status that returns a non-zero length → DONE, status error.
- **Per-transaction results** (every state)
  - NAK: relaunch the same transaction with the same toggle. The payload is replayed from the transaction's first byte.
  - STALL → DONE, status 1.
  - Error → DONE, status 3.
- **DONE**: pulse req_done, then return to IDLE. req_busy drops in that same cycle.
- remaining is 16-bit and never underflows; subtraction saturates at 0.

## Timing
- All outputs reset to 0; the state resets to IDLE.
- Reset asserted mid-transfer aborts the transfer silently: no req_done.
- tok_start fires one cycle after a state is entered, and one cycle after a NAK for a retry.
- xact_done arriving in the same cycle as tok_start is ignored.
- req_start while busy is ignored.
- rx_valid outside DATA IN is ignored.
- The quickest transfer (no data stage) is SETUP + STATUS. req_done rises 1 cycle after the STATUS xact_done.

## Configuration
- USB_CTRL_NAK_RETRY_EN
  - Defined: NAKs are retried. A 9-bit per-transaction counter clears on each tok_start of a new transaction. When it exceeds NAK_LIMIT, go to DONE with status 2.
  - Undefined: the first NAK goes to DONE with status 2. No counter is built.

## Test plan
- GET_DESCRIPTOR, wLength=18, device returns 18 bytes in one ACKed IN:
  - Token sequence SETUP(D0), IN(D1), OUT(D1) zero-length; status OK.
  - 18 app_rd_valid strobes.
- GET_DESCRIPTOR config, wLength=67, MAX_PKT=32:
  - IN lengths 32/32/3 with toggles D1/D0/D1, then OUT status (D1).
- SET_ADDRESS, wValue=5:
  - tx_data bytes 00 05 05 00 00 00 00 00, then IN status; status OK; no data stage.
- SET_LINE_CODING, wLength=7:
  - OUT of 7 bytes with 7 app_wr_get pulses, then IN status.
  - A NAK on the OUT replays the same 7 bytes with D1.
- STALL on the DATA IN stage → req_status=1, no status stage.
- With the macro defined and NAK_LIMIT=3: 4 consecutive NAKs → status 2.
- With the macro undefined: 1 NAK → status 2.
